// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream program loader for the LEGv8 instruction RAM.
//               Takes LEN_LO, LEN_HI, LEN little-endian words and an XOR
//               checksum over a valid/ready handshake. Writes each word to
//               sequential word addresses from 0. Holds the core until a load
//               finishes with a matching checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);

    localparam int c_nb = N / 8;
    localparam int c_bw = (c_nb > 1) ? $clog2(c_nb) : 1;
    localparam int c_lw = ADDR_W + 1;

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_len0  = 3'd1;
    localparam logic [2:0] c_len1  = 3'd2;
    localparam logic [2:0] c_data  = 3'd3;
    localparam logic [2:0] c_check = 3'd4;
    localparam logic [2:0] c_done  = 3'd5;
    localparam logic [2:0] c_err   = 3'd6;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [7:0]      r_len_lo;
    logic [c_lw-1:0] r_len;
    logic [c_lw-1:0] r_words_asm;
    logic [c_bw-1:0] r_byte_cnt;
    logic [N-1:0]    r_word;
    logic [N-1:0]    w_word_nxt;
    logic [7:0]      r_xor;
    logic [15:0]     w_len_full;
    logic            w_acc;
    logic            w_word_end;
    logic            w_last_word;
    logic            w_len_bad;

    assign in_ready    = (r_state == c_len0) || (r_state == c_len1) ||
                         (r_state == c_data) || (r_state == c_check);
    assign w_acc       = in_valid && in_ready;
    assign w_len_full  = {in_data, r_len_lo};
    // Zero words or more words than the RAM holds are both rejected.
    assign w_len_bad   = (w_len_full == 16'd0) ||
                         (32'(w_len_full) > (32'd1 << ADDR_W));
    assign w_word_end  = (r_byte_cnt == c_bw'(c_nb - 1));
    assign w_last_word = ((r_words_asm + c_lw'(1)) == r_len);

    // Merge the incoming byte into its little-endian lane of the partial word.
    always_comb begin
        w_word_nxt = r_word;
        for (int j = 0; j < c_nb; j++) begin
            if (r_byte_cnt == c_bw'(j)) begin
                w_word_nxt[8*j +: 8] = in_data;
            end
        end
    end

    // Next-state decode for the load sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start) w_state_nxt = c_len0;
            c_len0:  if (w_acc) w_state_nxt = c_len1;
            c_len1:  if (w_acc) w_state_nxt = w_len_bad ? c_err : c_data;
            c_data:  if (w_acc && w_word_end && w_last_word) w_state_nxt = c_check;
            c_check: if (w_acc) w_state_nxt = (in_data == r_xor) ? c_done : c_err;
            c_done:  if (start) w_state_nxt = c_len0;
            c_err:   if (start) w_state_nxt = c_len0;
            default: w_state_nxt = c_idle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Length capture, word assembly, checksum and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len_lo      <= 8'd0;
            r_len         <= '0;
            r_words_asm   <= '0;
            r_byte_cnt    <= '0;
            r_word        <= '0;
            r_xor         <= 8'd0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            mem_we   <= 1'b0;
            done     <= (w_state_nxt == c_done);
            error    <= (w_state_nxt == c_err);
            cpu_hold <= (w_state_nxt != c_done);

            // A new load starts from a clean slate; only reachable from idle states.
            if ((w_state_nxt == c_len0) && (r_state != c_len0)) begin
                r_xor         <= 8'd0;
                r_byte_cnt    <= '0;
                r_words_asm   <= '0;
                words_written <= '0;
            end

            if (w_acc) begin
                case (r_state)
                    c_len0: r_len_lo <= in_data;
                    c_len1: r_len    <= c_lw'(w_len_full);
                    c_data: begin
                        r_xor  <= r_xor ^ in_data;
                        r_word <= w_word_nxt;
                        if (w_word_end) begin
                            r_byte_cnt    <= '0;
                            r_words_asm   <= r_words_asm + c_lw'(1);
                            mem_we        <= 1'b1;
                            mem_addr      <= r_words_asm[ADDR_W-1:0];
                            mem_wdata     <= w_word_nxt;
                            words_written <= words_written + c_lw'(1);
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_bw'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader: directed vector table,
//               hand-written reset/reload sequences and randomized loads
//               compared against a stream-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int N      = 32;
    localparam int ADDR_W = 10;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'd0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [N-1:0]      mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_written;

    always #5 clk = ~clk;

    imem_loader #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    int total = 0;
    int bad   = 0;
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];

    typedef struct {
        int          n;
        logic [95:0] b;
        int          gap;
        bit          smid;
        bit          d;
        bit          e;
        int          ww;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Capture every RAM write; the count must already include it.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check("ww_with_we", 64'(words_written), 64'(got_addr.size() + 1));
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
        end
    end

    // Stream-level reference: length rules, little-endian words, XOR of data.
    function automatic void model(input logic [7:0] s[$], output logic [31:0] w[$],
                                  output bit d, output bit e);
        int len;
        logic [7:0] x;
        w   = {};
        len = int'({s[1], s[0]});
        if (len == 0 || len > (1 << ADDR_W)) begin
            d = 1'b0;
            e = 1'b1;
            return;
        end
        x = 8'd0;
        for (int i = 0; i < len; i++)
            w.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
        for (int j = 0; j < 4 * len; j++)
            x = x ^ s[2+j];
        d = (s[2+4*len] == x);
        e = !d;
    endfunction

    task automatic put_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL handshake: in_ready=%b after %0d cycles, want 1", in_ready, n);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
    endtask

    task automatic run_load(input logic [7:0] s[$], input int gap_mode, input bit start_mid);
        got_addr.delete();
        got_data.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                if (start_mid && i == 6) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            put_byte(s[i]);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input bit d, input bit e, input int ww,
                                input logic [31:0] w[$]);
        check({tag, " done"}, 64'(done), 64'(d));
        check({tag, " error"}, 64'(error), 64'(e));
        check({tag, " cpu_hold"}, 64'(cpu_hold), 64'(!d));
        check({tag, " words_written"}, 64'(words_written), 64'(ww));
        check({tag, " nwrites"}, 64'(got_addr.size()), 64'(w.size()));
        for (int i = 0; i < w.size() && i < got_addr.size(); i++) begin
            check($sformatf("%s addr%0d", tag, i), 64'(got_addr[i]), 64'(i));
            check($sformatf("%s data%0d", tag, i), 64'(got_data[i]), 64'(w[i]));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " in_ready"}, 64'(in_ready), 64'd0);
        check({tag, " mem_we"}, 64'(mem_we), 64'd0);
        check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, " cpu_hold"}, 64'(cpu_hold), 64'd1);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " error"}, 64'(error), 64'd0);
        check({tag, " words_written"}, 64'(words_written), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s[$];
        logic [31:0] w[$];
        bit          d;
        bit          e;
        logic [7:0]  x;
        int          len;

        vt[0] = '{11, 96'h02_00_31_06_00_91_11_40_09_F8_06_00, 0, 1'b0, 1'b1, 1'b0, 2,
                  32'h91000631, 32'hF8094011};
        vt[1] = '{11, 96'h02_00_31_06_00_91_11_40_09_F8_07_00, 0, 1'b0, 1'b0, 1'b1, 2,
                  32'h91000631, 32'hF8094011};
        vt[2] = '{2, 96'h00_00_00_00_00_00_00_00_00_00_00_00, 0, 1'b0, 1'b0, 1'b1, 0,
                  32'h0, 32'h0};
        vt[3] = '{2, 96'h01_04_00_00_00_00_00_00_00_00_00_00, 0, 1'b0, 1'b0, 1'b1, 0,
                  32'h0, 32'h0};
        vt[4] = '{11, 96'h02_00_31_06_00_91_11_40_09_F8_06_00, 1, 1'b1, 1'b1, 1'b0, 2,
                  32'h91000631, 32'hF8094011};
        vt[5] = '{7, 96'h01_00_FF_03_E0_8B_97_00_00_00_00_00, 0, 1'b0, 1'b1, 1'b0, 1,
                  32'h8BE003FF, 32'h0};

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;

        // Directed vector table.
        for (int v = 0; v < 6; v++) begin
            s = {};
            w = {};
            for (int i = 0; i < vt[v].n; i++) s.push_back(vt[v].b[95-8*i -: 8]);
            if (vt[v].ww > 0) w.push_back(vt[v].w0);
            if (vt[v].ww > 1) w.push_back(vt[v].w1);
            run_load(s, vt[v].gap, vt[v].smid);
            check_result($sformatf("vec%0d", v), vt[v].d, vt[v].e, vt[v].ww, w);
        end

        // Reload after DONE: status clears one cycle after start.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("reload done", 64'(done), 64'd0);
        check("reload cpu_hold", 64'(cpu_hold), 64'd1);
        check("reload words_written", 64'(words_written), 64'd0);
        check("reload in_ready", 64'(in_ready), 64'd1);

        // Reset after six data bytes, then a fresh 1-word load.
        got_addr.delete();
        got_data.delete();
        s = '{8'h02, 8'h00, 8'h31, 8'h06, 8'h00, 8'h91, 8'h11, 8'h40};
        foreach (s[i]) put_byte(s[i]);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b1;
        s = '{8'h01, 8'h00, 8'hFF, 8'h03, 8'hE0, 8'h8B, 8'h97};
        w = '{32'h8BE003FF};
        run_load(s, 0, 1'b0);
        check_result("fresh", 1'b1, 1'b0, 1, w);

        // Randomized loads against the reference model.
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = 1025;
                default: len = $urandom_range(1, 6);
            endcase
            s = {};
            s.push_back(8'(len));
            s.push_back(8'(len >> 8));
            if (len >= 1 && len <= 1024) begin
                x = 8'd0;
                for (int j = 0; j < 4 * len; j++) begin
                    s.push_back(8'($urandom));
                    x = x ^ s[s.size()-1];
                end
                if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
                s.push_back(x);
            end
            model(s, w, d, e);
            run_load(s, 2, 1'b0);
            check_result($sformatf("rnd%0d", it), d, e, w.size(), w);
        end

        // Full-memory load: last write lands at 3FF.
        s = '{8'h00, 8'h04};
        x = 8'd0;
        for (int j = 0; j < 4096; j++) begin
            s.push_back(8'($urandom));
            x = x ^ s[s.size()-1];
        end
        s.push_back(x);
        model(s, w, d, e);
        run_load(s, 0, 1'b0);
        check_result("maxlen", d, e, 1024, w);
        if (got_addr.size() > 0)
            check("maxlen lastaddr", 64'(got_addr[got_addr.size()-1]), 64'h3FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
